// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and the
// bit-decision helper used by both the transmit and receive engines.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  localparam logic [3:0] SAMP_FIRST = 4'd7;
  localparam logic [3:0] SAMP_MID   = 4'd8;
  localparam logic [3:0] SAMP_LAST  = 4'd9;
  localparam logic [3:0] SAMP_END   = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic [1:0] STOP_TWO   = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div-1 and flags the terminal count.
// A restart pulse realigns the count to the current cycle.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_last;
  logic             w_term;

  assign w_last = i_div - {{(DIV_W-1){1'b0}}, 1'b1};
  // ">=" keeps the counter from running away if the divisor shrinks mid-count.
  assign w_term = (i_div != '0) && (r_cnt >= w_last);
  assign o_tick = w_term && !i_restart;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled deframer with majority-vote bit decisions,
// one-cycle FIFO write strobe and sticky parity/framing/overrun flags.
`timescale 1ns/1ps
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic             i_parity_en,
  input  logic             i_parity_odd,
  input  logic [1:0]       i_stop_bits,
  input  logic             i_rx_line,
  input  logic             i_fifo_full,
  input  logic             i_err_clr,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  output logic             o_rx_busy,
  output logic             o_parity_error,
  output logic             o_framing_error,
  output logic             o_overrun_error
);

  logic        r_sync1, r_sync2;
  uart_state_e r_state;
  logic [3:0]  r_samp_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_s7, r_s8;
  logic        r_par_en, r_par_odd, r_stop_two;
  logic        r_frm_par, r_frm_frm;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid, r_par_err, r_frm_err, r_ovr_err;

  logic w_rx, w_active, w_start, w_tick, w_dec, w_end, w_bit, w_par_exp, w_done;

  assign w_rx      = r_sync2;
  assign w_active  = (r_state != StIdle);
  assign w_start   = (r_state == StIdle) && !w_rx && (i_baud_div != '0);
  assign w_dec     = w_active && w_tick && (r_samp_cnt == SAMP_LAST);
  assign w_end     = w_active && w_tick && (r_samp_cnt == SAMP_END);
  assign w_bit     = maj3(r_s7, r_s8, w_rx);
  assign w_par_exp = (^r_shift) ^ r_par_odd;
  assign w_done    = w_dec && (((r_state == StStop1) && !r_stop_two) || (r_state == StStop2));

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_start),
    .i_div     (i_baud_div),
    .o_tick    (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_line;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_s7       <= 1'b1;
      r_s8       <= 1'b1;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_stop_two <= 1'b0;
      r_frm_par  <= 1'b0;
      r_frm_frm  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_ovr_err  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      // Clear first so a same-cycle set further down takes priority.
      if (i_err_clr) begin
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
        r_ovr_err <= 1'b0;
      end
      if (w_active && w_tick) begin
        r_samp_cnt <= r_samp_cnt + 4'd1;
        if (r_samp_cnt == SAMP_FIRST) r_s7 <= w_rx;
        if (r_samp_cnt == SAMP_MID)   r_s8 <= w_rx;
      end

      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state    <= StStart;
            r_par_en   <= i_parity_en;
            r_par_odd  <= i_parity_odd;
            r_stop_two <= (i_stop_bits == STOP_TWO);
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_frm_par  <= 1'b0;
            r_frm_frm  <= 1'b0;
          end
        end
        StStart: begin
          if (w_dec && w_bit) r_state <= StIdle;
          else if (w_end)     r_state <= StData;
        end
        StData: begin
          if (w_dec) r_shift <= {w_bit, r_shift[7:1]};
          if (w_end) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) r_state <= r_par_en ? StParity : StStop1;
          end
        end
        StParity: begin
          if (w_dec && (w_bit != w_par_exp)) r_frm_par <= 1'b1;
          if (w_end) r_state <= StStop1;
        end
        StStop1: begin
          if (w_dec && !w_bit) r_frm_frm <= 1'b1;
          if (w_done)     r_state <= StIdle;
          else if (w_end) r_state <= StStop2;
        end
        StStop2: begin
          if (w_dec && !w_bit) r_frm_frm <= 1'b1;
          if (w_done) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (w_done) begin
        if (!i_fifo_full) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_ovr_err <= 1'b1;
        end
        if (r_frm_par)            r_par_err <= 1'b1;
        if (r_frm_frm || !w_bit)  r_frm_err <= 1'b1;
      end
    end
  end

  assign o_rx_data       = r_rx_data;
  assign o_rx_valid      = r_rx_valid;
  assign o_rx_busy       = w_active;
  assign o_parity_error  = r_par_err;
  assign o_framing_error = r_frm_err;
  assign o_overrun_error = r_ovr_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serialises hand-picked frames at baud_div=27
// and checks delivered bytes, strobe counts and sticky error flags.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int unsigned BIT_CYC = 27 * 16;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_baud_div;
  logic        i_parity_en, i_parity_odd;
  logic [1:0]  i_stop_bits;
  logic        i_rx_line, i_fifo_full, i_err_clr;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid, o_rx_busy;
  logic        o_parity_error, o_framing_error, o_overrun_error;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] strobe_q[$];
  bit         busy_seen = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(
    .DIV_W (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_baud_div      (i_baud_div),
    .i_parity_en     (i_parity_en),
    .i_parity_odd    (i_parity_odd),
    .i_stop_bits     (i_stop_bits),
    .i_rx_line       (i_rx_line),
    .i_fifo_full     (i_fifo_full),
    .i_err_clr       (i_err_clr),
    .o_rx_data       (o_rx_data),
    .o_rx_valid      (o_rx_valid),
    .o_rx_busy       (o_rx_busy),
    .o_parity_error  (o_parity_error),
    .o_framing_error (o_framing_error),
    .o_overrun_error (o_overrun_error)
  );

  // Every cycle of rx_valid is logged, so a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (o_rx_valid) strobe_q.push_back(o_rx_data);
    if (o_rx_busy)  busy_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int idx);
    return (idx < strobe_q.size()) ? {24'h0, strobe_q[idx]} : 32'hDEAD;
  endfunction

  task automatic hold_line(input logic b, input int unsigned cycles);
    i_rx_line = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input int nstop, input logic stop_val);
    hold_line(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) hold_line(d[i], BIT_CYC);
    if (par_on) hold_line(par_bit, BIT_CYC);
    hold_line(stop_val, BIT_CYC);
    if (nstop == 2) hold_line(1'b1, BIT_CYC);
    i_rx_line = 1'b1;
  endtask

  task automatic check_flags(input string tag, input logic p, input logic f, input logic o);
    check_eq({tag, "_par"}, {31'h0, o_parity_error}, {31'h0, p});
    check_eq({tag, "_frm"}, {31'h0, o_framing_error}, {31'h0, f});
    check_eq({tag, "_ovr"}, {31'h0, o_overrun_error}, {31'h0, o});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n      = 1'b0;
    i_baud_div   = 16'd27;
    i_parity_en  = 1'b1;
    i_parity_odd = 1'b1;
    i_stop_bits  = 2'd1;
    i_rx_line    = 1'b1;
    i_fifo_full  = 1'b0;
    i_err_clr    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", {24'h0, o_rx_data}, 32'h0);
    check_eq("rst_valid", {31'h0, o_rx_valid}, 32'h0);
    check_eq("rst_busy", {31'h0, o_rx_busy}, 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    hold_line(1'b1, 20);

    // 1: odd parity, 0xA5 has four ones so the parity bit is 1.
    strobe_q.delete();
    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b1);
    hold_line(1'b1, 20);
    check_eq("t1_strobes", strobe_q.size(), 32'd1);
    check_eq("t1_data", {24'h0, o_rx_data}, 32'hA5);
    check_eq("t1_busy", {31'h0, o_rx_busy}, 32'h0);
    check_flags("t1", 1'b0, 1'b0, 1'b0);

    // 2: 0x3C also has four ones; a parity bit of 0 is wrong for odd parity.
    strobe_q.delete();
    send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b1);
    hold_line(1'b1, 20);
    check_eq("t2_strobes", strobe_q.size(), 32'd1);
    check_eq("t2_data", q_at(0), 32'h3C);
    check_flags("t2", 1'b1, 1'b0, 1'b0);
    hold_line(1'b1, 100);
    check_eq("t2_par_held", {31'h0, o_parity_error}, 32'h1);
    pulse_clr();
    check_eq("t2_par_clr", {31'h0, o_parity_error}, 32'h0);

    // 3: no parity, stop bit driven low, then a clean frame.
    i_parity_en = 1'b0;
    strobe_q.delete();
    send_frame(8'h55, 1'b0, 1'b0, 1, 1'b0);
    hold_line(1'b1, 2 * BIT_CYC);
    check_eq("t3_strobes", strobe_q.size(), 32'd1);
    check_eq("t3_data", q_at(0), 32'h55);
    check_flags("t3", 1'b0, 1'b1, 1'b0);
    pulse_clr();
    strobe_q.delete();
    send_frame(8'h12, 1'b0, 1'b0, 1, 1'b1);
    hold_line(1'b1, 20);
    check_eq("t3b_strobes", strobe_q.size(), 32'd1);
    check_eq("t3b_data", q_at(0), 32'h12);
    check_flags("t3b", 1'b0, 1'b0, 1'b0);

    // 4: 135-cycle glitch is a false start.
    strobe_q.delete();
    busy_seen = 1'b0;
    hold_line(1'b0, 135);
    i_rx_line = 1'b1;
    for (int c = 0; c < 16 * 27 && o_rx_busy; c++) @(negedge clk);
    check_eq("t4_busy_fall", {31'h0, o_rx_busy}, 32'h0);
    check_eq("t4_busy_seen", {31'h0, busy_seen}, 32'h1);
    hold_line(1'b1, BIT_CYC);
    check_eq("t4_strobes", strobe_q.size(), 32'd0);

    // 5: two stop bits, back-to-back frames, then the same with the FIFO full.
    i_stop_bits = 2'd2;
    strobe_q.delete();
    send_frame(8'h00, 1'b0, 1'b0, 2, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 2, 1'b1);
    hold_line(1'b1, 20);
    check_eq("t5_strobes", strobe_q.size(), 32'd2);
    check_eq("t5_first", q_at(0), 32'h00);
    check_eq("t5_second", q_at(1), 32'hFF);
    check_flags("t5", 1'b0, 1'b0, 1'b0);
    strobe_q.delete();
    send_frame(8'h00, 1'b0, 1'b0, 2, 1'b1);
    i_fifo_full = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b0, 2, 1'b1);
    hold_line(1'b1, 20);
    i_fifo_full = 1'b0;
    check_eq("t5b_strobes", strobe_q.size(), 32'd1);
    check_eq("t5b_first", q_at(0), 32'h00);
    check_eq("t5b_data", {24'h0, o_rx_data}, 32'h00);
    check_flags("t5b", 1'b0, 1'b0, 1'b1);

    // 6: reset during data bit 4 of 0xC3 (bits 0..3 = 1,1,0,0), then abort the frame.
    i_stop_bits = 2'd1;
    strobe_q.delete();
    hold_line(1'b0, BIT_CYC);
    hold_line(1'b1, BIT_CYC);
    hold_line(1'b1, BIT_CYC);
    hold_line(1'b0, BIT_CYC);
    hold_line(1'b0, BIT_CYC);
    hold_line(1'b0, 200);
    check_eq("t6_busy_mid", {31'h0, o_rx_busy}, 32'h1);
    i_rst_n   = 1'b0;
    i_rx_line = 1'b1;
    @(negedge clk);
    i_rst_n = 1'b1;
    check_eq("t6_busy_rst", {31'h0, o_rx_busy}, 32'h0);
    check_eq("t6_valid_rst", {31'h0, o_rx_valid}, 32'h0);
    check_eq("t6_data_rst", {24'h0, o_rx_data}, 32'h0);
    check_flags("t6_rst", 1'b0, 1'b0, 1'b0);
    hold_line(1'b1, 2 * BIT_CYC);
    check_eq("t6_no_strobe", strobe_q.size(), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1);
    hold_line(1'b1, 20);
    check_eq("t6_strobes", strobe_q.size(), 32'd1);
    check_eq("t6_data", {24'h0, o_rx_data}, 32'h81);
    check_flags("t6", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
